// File: rtl/ws2812b_frame_streamer_pkg.sv
// Shared definitions for the WS2812B frame streamer and the serializer:
// GRB byte order, fetch FSM encoding and the 24-bit pixel word type.
package ws2812b_frame_streamer_pkg;

    localparam logic [1:0] BYTE_G = 2'd0;
    localparam logic [1:0] BYTE_R = 2'd1;
    localparam logic [1:0] BYTE_B = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP,
        STAGE
    } fetch_state_t;

    typedef logic [23:0] pixel_word_t;

    function automatic pixel_word_t pack_grb(input logic [7:0] g,
                                             input logic [7:0] r,
                                             input logic [7:0] b);
        return {g, r, b};
    endfunction

endpackage

// File: rtl/ws2812b_frame_streamer_if.sv
// SRAM read port plus serializer word handshake seen by the frame streamer.
// master = streamer side, slave = SRAM controller / serializer side.
interface ws2812b_frame_streamer_if #(
    parameter int ADDR_W = 17
);
    import ws2812b_frame_streamer_pkg::*;

    logic [ADDR_W-1:0] r_address;
    logic              r_request;
    logic              r_done;
    logic [7:0]        r_data;
    pixel_word_t       bitstream;
    logic              bitstream_available;
    logic              bitstream_read;

    modport master (
        output r_address, r_request, bitstream, bitstream_available,
        input  r_done, r_data, bitstream_read
    );

    modport slave (
        input  r_address, r_request, bitstream, bitstream_available,
        output r_done, r_data, bitstream_read
    );

endinterface

// File: rtl/ws2812b_pixel_stage.sv
// One-word staging register plus the output slot with its available/read
// handshake. Knows nothing about SRAM addressing.
module ws2812b_pixel_stage
    import ws2812b_frame_streamer_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        byte_we,
    input  logic [1:0]  byte_sel,
    input  logic [7:0]  byte_in,
    input  logic        transfer,
    output logic        slot_free,
    input  logic        word_read,
    output pixel_word_t word_out,
    output logic        word_valid
);

    logic [7:0] g_q, r_q, b_q;

    // The slot can accept a new word when empty or being consumed this cycle.
    assign slot_free = !word_valid || word_read;

    // Capture one byte into its GRB position in the staging register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            g_q <= '0;
            r_q <= '0;
            b_q <= '0;
        end else if (byte_we) begin
            case (byte_sel)
                BYTE_G:  g_q <= byte_in;
                BYTE_R:  r_q <= byte_in;
                default: b_q <= byte_in;
            endcase
        end
    end

    // Output slot: load on transfer (wins over a same-cycle read), else clear on read.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            word_out   <= '0;
            word_valid <= 1'b0;
        end else if (transfer) begin
            word_out   <= pack_grb(g_q, r_q, b_q);
            word_valid <= 1'b1;
        end else if (word_read) begin
            word_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ws2812b_frame_streamer.sv
// WS2812B frame streamer: on each frame tick fetches LEDCOUNT GRB triplets
// from SRAM and hands them to the serializer one 24-bit word at a time.
// Optional macro WS2812B_STREAM_DIM_EN adds a 3-bit 'dim' input that
// right-shifts every captured byte.
module ws2812b_frame_streamer
    import ws2812b_frame_streamer_pkg::*;
#(
    parameter int                LEDCOUNT  = 36,
    parameter int                ADDR_W    = 17,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic clk,
    input  logic resetn,
    input  logic frame_tick,
`ifdef WS2812B_STREAM_DIM_EN
    input  logic [2:0] dim,
`endif
    ws2812b_frame_streamer_if.master link,
    output logic busy,
    output logic frame_done
);

    localparam int CNT_W = $clog2(LEDCOUNT + 1);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  led_left_q;
    logic [CNT_W-1:0]  out_left_q;
    logic [1:0]        byte_idx_q;
    logic              start, capture, transfer, slot_free;
    logic [7:0]        byte_in;

`ifdef WS2812B_STREAM_DIM_EN
    assign byte_in = link.r_data >> dim;
`else
    assign byte_in = link.r_data;
`endif

    assign link.r_address = addr_q;

    // Fetch FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Fetch FSM next state and strobes.
    always_comb begin
        state_d        = state_q;
        start          = 1'b0;
        capture        = 1'b0;
        transfer       = 1'b0;
        link.r_request = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_tick && !busy) begin
                    start   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                link.r_request = 1'b1;
                if (link.r_done) begin
                    capture = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = (byte_idx_q == BYTE_B) ? STAGE : REQ;
            end
            STAGE: begin
                if (slot_free) begin
                    transfer = 1'b1;
                    state_d  = (led_left_q != '0) ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address, byte index and fetch-side LED counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_q     <= '0;
            led_left_q <= '0;
            byte_idx_q <= BYTE_G;
        end else begin
            if (start) begin
                addr_q     <= BASE_ADDR;
                led_left_q <= CNT_W'(LEDCOUNT);
                byte_idx_q <= BYTE_G;
            end
            if (capture) addr_q <= addr_q + 1'b1;
            if (state_q == GAP) begin
                if (byte_idx_q == BYTE_B) led_left_q <= led_left_q - 1'b1;
                else                      byte_idx_q <= byte_idx_q + 2'd1;
            end
            if (transfer) byte_idx_q <= BYTE_G;
        end
    end

    // Frame completion tracks consumed words, not fetched ones, so busy
    // covers the tail where the last word still sits in the output slot.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy       <= 1'b0;
            frame_done <= 1'b0;
            out_left_q <= '0;
        end else begin
            frame_done <= 1'b0;
            if (start) begin
                busy       <= 1'b1;
                out_left_q <= CNT_W'(LEDCOUNT);
            end else if (busy && link.bitstream_available && link.bitstream_read) begin
                out_left_q <= out_left_q - 1'b1;
                if (out_left_q == CNT_W'(1)) begin
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end
            end
        end
    end

    ws2812b_pixel_stage u_stage (
        .clk        (clk),
        .resetn     (resetn),
        .byte_we    (capture),
        .byte_sel   (byte_idx_q),
        .byte_in    (byte_in),
        .transfer   (transfer),
        .slot_free  (slot_free),
        .word_read  (link.bitstream_read),
        .word_out   (link.bitstream),
        .word_valid (link.bitstream_available)
    );

endmodule

// File: tb/tb_ws2812b_frame_streamer.sv
// Bench for ws2812b_frame_streamer: two instances (4 LEDs at base 0, and
// 1 LED at the top of the address space), an SRAM responder and a
// serializer consumer per instance, and a frame-level reference model.
// Compile with WS2812B_STREAM_DIM_EN to also exercise the dim input.
module tb_ws2812b_frame_streamer;
    import ws2812b_frame_streamer_pkg::*;

    localparam int             AW     = 17;
    localparam int             LC_A   = 4;
    localparam int             LC_B   = 1;
    localparam logic [AW-1:0]  BASE_A = 17'h00000;
    localparam logic [AW-1:0]  BASE_B = 17'h1FFFE;

    logic clk = 1'b0;
    logic resetn;
    logic tick_a, tick_b;
    logic stray_done;
`ifdef WS2812B_STREAM_DIM_EN
    logic [2:0] dim_v;
`endif

    int checks = 0;
    int errors = 0;
    int frames_a = 0;

    logic [7:0] mem [0:(1<<AW)-1];

    int          lat      [2];
    int          rdelay   [2];
    int          exp_addr [2];
    int          fd_cnt   [2];
    pixel_word_t exp_q    [2][$];

    logic          done_drv [2];
    logic [7:0]    data_drv [2];
    logic          rd_drv   [2];
    logic          req_w    [2];
    logic          avail_w  [2];
    logic          busy_w   [2];
    logic          fdone_w  [2];
    logic [AW-1:0] addr_w   [2];
    pixel_word_t   bits_w   [2];

    always #5 clk = ~clk;

    ws2812b_frame_streamer_if #(.ADDR_W(AW)) ifa ();
    ws2812b_frame_streamer_if #(.ADDR_W(AW)) ifb ();

    assign ifa.r_done         = done_drv[0] | stray_done;
    assign ifa.r_data         = data_drv[0];
    assign ifa.bitstream_read = rd_drv[0];
    assign ifb.r_done         = done_drv[1];
    assign ifb.r_data         = data_drv[1];
    assign ifb.bitstream_read = rd_drv[1];
    assign req_w[0]   = ifa.r_request;
    assign req_w[1]   = ifb.r_request;
    assign avail_w[0] = ifa.bitstream_available;
    assign avail_w[1] = ifb.bitstream_available;
    assign addr_w[0]  = ifa.r_address;
    assign addr_w[1]  = ifb.r_address;
    assign bits_w[0]  = ifa.bitstream;
    assign bits_w[1]  = ifb.bitstream;

    ws2812b_frame_streamer #(.LEDCOUNT(LC_A), .ADDR_W(AW), .BASE_ADDR(BASE_A)) dut_a (
        .clk        (clk),
        .resetn     (resetn),
        .frame_tick (tick_a),
`ifdef WS2812B_STREAM_DIM_EN
        .dim        (dim_v),
`endif
        .link       (ifa.master),
        .busy       (busy_w[0]),
        .frame_done (fdone_w[0])
    );

    ws2812b_frame_streamer #(.LEDCOUNT(LC_B), .ADDR_W(AW), .BASE_ADDR(BASE_B)) dut_b (
        .clk        (clk),
        .resetn     (resetn),
        .frame_tick (tick_b),
`ifdef WS2812B_STREAM_DIM_EN
        .dim        (dim_v),
`endif
        .link       (ifb.master),
        .busy       (busy_w[1]),
        .frame_done (fdone_w[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] dim_now();
`ifdef WS2812B_STREAM_DIM_EN
        return dim_v;
`else
        return 3'd0;
`endif
    endfunction

    // Reference: LED i of a frame is the three bytes at base+3i.. (mod 2^AW).
    function automatic pixel_word_t model_word(input logic [AW-1:0] base, input int led);
        logic [7:0]    b [3];
        logic [AW-1:0] a;
        for (int k = 0; k < 3; k++) begin
            a    = base + AW'(3 * led + k);
            b[k] = mem[a] >> dim_now();
        end
        return {b[0], b[1], b[2]};
    endfunction

    task automatic tick_once();
        @(posedge clk); #1;
    endtask

    task automatic start_frame(input int c);
        logic [AW-1:0] base;
        int            n;
        base = (c == 0) ? BASE_A : BASE_B;
        n    = (c == 0) ? LC_A : LC_B;
        exp_addr[c] = int'(base);
        for (int i = 0; i < n; i++) exp_q[c].push_back(model_word(base, i));
        if (c == 0) tick_a = 1'b1; else tick_b = 1'b1;
        tick_once();
        tick_a = 1'b0;
        tick_b = 1'b0;
        check("req_after_tick", 32'(req_w[c]), 32'd1);
        check("busy_after_tick", 32'(busy_w[c]), 32'd1);
    endtask

    task automatic wait_idle(input int c, input int limit, input string tag);
        int n = 0;
        while ((busy_w[c] || exp_q[c].size() != 0) && n < limit) begin
            tick_once();
            n++;
        end
        check(tag, 32'(n < limit), 32'd1);
        tick_once();
    endtask

    for (genvar c = 0; c < 2; c++) begin : g_ch
        // SRAM responder: r_done arrives lat[c] cycles after the request is seen.
        initial begin : sram_model
            int            pend;
            logic [AW-1:0] a;
            pend = 0;
            a    = '0;
            done_drv[c] = 1'b0;
            data_drv[c] = '0;
            forever begin
                @(negedge clk);
                done_drv[c] = 1'b0;
                if (!resetn) begin
                    pend = 0;
                end else if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        done_drv[c] = 1'b1;
                        data_drv[c] = mem[a];
                    end
                end else if (req_w[c]) begin
                    a = addr_w[c];
                    check("sram_addr", 32'(a), 32'(exp_addr[c]));
                    exp_addr[c] = (exp_addr[c] + 1) % (1 << AW);
                    pend = lat[c];
                end
            end
        end

        // Serializer: consume each word rdelay[c] cycles after it appears.
        initial begin : ser_model
            int   wait_cnt;
            logic last_pending;
            wait_cnt     = -1;
            last_pending = 1'b0;
            rd_drv[c]    = 1'b0;
            forever begin
                @(negedge clk);
                rd_drv[c] = 1'b0;
                if (fdone_w[c]) fd_cnt[c]++;
                if (last_pending) begin
                    check("frame_done_pulse", 32'(fdone_w[c]), 32'd1);
                    check("busy_fall", 32'(busy_w[c]), 32'd0);
                    last_pending = 1'b0;
                end
                if (resetn && avail_w[c]) begin
                    if (wait_cnt < 0) wait_cnt = rdelay[c];
                    if (wait_cnt == 0) begin
                        check("word_expected", 32'(exp_q[c].size() > 0), 32'd1);
                        if (exp_q[c].size() > 0) begin
                            check("word", 32'(bits_w[c]), 32'(exp_q[c].pop_front()));
                            last_pending = (exp_q[c].size() == 0);
                        end
                        rd_drv[c] = 1'b1;
                        wait_cnt  = -1;
                    end else begin
                        wait_cnt--;
                    end
                end else begin
                    wait_cnt = -1;
                end
            end
        end
    end

    initial begin : main
        int n;
        int viol;
        resetn     = 1'b0;
        tick_a     = 1'b0;
        tick_b     = 1'b0;
        stray_done = 1'b0;
`ifdef WS2812B_STREAM_DIM_EN
        dim_v = 3'd0;
`endif
        for (int i = 0; i < 2; i++) begin
            lat[i] = 2; rdelay[i] = 3; exp_addr[i] = 0; fd_cnt[i] = 0;
        end
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 12; i++) mem[i] = 8'(8'h10 + i);

        repeat (3) tick_once();
        for (int c = 0; c < 2; c++) begin
            check("rst_r_address", 32'(addr_w[c]), 32'd0);
            check("rst_r_request", 32'(req_w[c]), 32'd0);
            check("rst_bitstream", 32'(bits_w[c]), 32'd0);
            check("rst_available", 32'(avail_w[c]), 32'd0);
            check("rst_busy", 32'(busy_w[c]), 32'd0);
            check("rst_frame_done", 32'(fdone_w[c]), 32'd0);
        end
        resetn = 1'b1;
        tick_once();

        // Basic frame: bytes 0x10..0x1B, reader 3 cycles after available.
        check("model_led3", 32'(model_word(BASE_A, 3)), 32'h191A1B);
        start_frame(0);
        n = 1;
        while (!avail_w[0] && n < 100) begin tick_once(); n++; end
        check("first_word_latency", 32'(n), 32'd14);
        wait_idle(0, 500, "basic_frame_timeout");
        frames_a++;
        check("basic_frame_done_count", 32'(fd_cnt[0]), 32'(frames_a));
        check("basic_busy_after", 32'(busy_w[0]), 32'd0);

        // Slow serializer: prefetch one word, then no SRAM traffic while blocked.
        rdelay[0] = 200;
        start_frame(0);
        n = 0;
        while (!avail_w[0] && n < 100) begin tick_once(); n++; end
        repeat (40) tick_once();
        viol = 0;
        repeat (140) begin tick_once(); if (req_w[0]) viol++; end
        check("stall_no_request", 32'(viol), 32'd0);
        check("stall_nothing_consumed", 32'(exp_q[0].size()), 32'(LC_A));
        wait_idle(0, 3000, "slow_frame_timeout");
        frames_a++;

        // Address wrap on the 1-LED instance.
        rdelay[1] = 2;
        start_frame(1);
        wait_idle(1, 500, "wrap_frame_timeout");
        check("wrap_frame_done_count", 32'(fd_cnt[1]), 32'd1);

        // Repeated ticks while busy must not restart the frame.
        rdelay[0] = 3;
        start_frame(0);
        n = 0;
        while (busy_w[0] && n < 400) begin
            tick_a = ((n % 5) == 4);
            tick_once();
            n++;
        end
        tick_a = 1'b0;
        check("retick_frame_timeout", 32'(n < 400), 32'd1);
        tick_once();
        frames_a++;
        check("retick_queue_drained", 32'(exp_q[0].size()), 32'd0);
        check("retick_frame_done_count", 32'(fd_cnt[0]), 32'(frames_a));
        for (int i = 0; i < 12; i++) mem[i] = 8'($urandom);
        start_frame(0);
        wait_idle(0, 500, "after_retick_timeout");
        frames_a++;

        // Randomized frames: random contents, SRAM latency and reader delay.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 12; i++) mem[i] = 8'($urandom);
            lat[0]    = int'($urandom_range(1, 4));
            rdelay[0] = int'($urandom_range(0, 6));
            start_frame(0);
            wait_idle(0, 800, "random_frame_timeout");
            frames_a++;
        end
        check("random_frame_done_count", 32'(fd_cnt[0]), 32'(frames_a));

        // Reset mid-frame with a request pending and a word in the slot.
        lat[0]    = 2;
        rdelay[0] = 200;
        start_frame(0);
        n = 0;
        while (!(req_w[0] && avail_w[0]) && n < 200) begin tick_once(); n++; end
        check("reach_req_and_avail", 32'(n < 200), 32'd1);
        resetn = 1'b0;
        tick_once();
        check("midrst_r_request", 32'(req_w[0]), 32'd0);
        check("midrst_available", 32'(avail_w[0]), 32'd0);
        check("midrst_busy", 32'(busy_w[0]), 32'd0);
        resetn     = 1'b1;
        stray_done = 1'b1;
        tick_once();
        stray_done = 1'b0;
        exp_q[0].delete();
        repeat (2) tick_once();
        check("stray_r_request", 32'(req_w[0]), 32'd0);
        check("stray_available", 32'(avail_w[0]), 32'd0);
        check("stray_busy", 32'(busy_w[0]), 32'd0);
        check("stray_bitstream", 32'(bits_w[0]), 32'd0);
        check("stray_r_address", 32'(addr_w[0]), 32'd0);
        check("stray_no_frame_done", 32'(fd_cnt[0]), 32'(frames_a));
        rdelay[0] = 2;
        start_frame(0);
        wait_idle(0, 800, "post_reset_frame_timeout");
        frames_a++;

`ifdef WS2812B_STREAM_DIM_EN
        // Dim: each byte shifted right by 2 at capture.
        dim_v  = 3'd2;
        mem[0] = 8'hFF;
        mem[1] = 8'h80;
        mem[2] = 8'h04;
        rdelay[0] = 1;
        start_frame(0);
        n = 0;
        while (!avail_w[0] && n < 100) begin tick_once(); n++; end
        check("dim_word", 32'(bits_w[0]), 32'h3F2001);
        wait_idle(0, 800, "dim_frame_timeout");
        frames_a++;
        dim_v = 3'd0;
`endif

        check("total_frame_done_count", 32'(fd_cnt[0]), 32'(frames_a));
        check("final_busy", 32'(busy_w[0]), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
